// File: rtl/user_id_controller_if.sv
// Keypad, ROM and status signals of the user-ID front end.
// The controller takes the slave side; the keypad/ROM/password side takes the master side.
interface user_id_controller_if;
  logic       Game_Enter;
  logic [3:0] User_digit;
  logic       LogOut;
  logic [3:0] rom_q;
  logic [4:0] rom_addr;
  logic       Matched_ID;
  logic [4:0] Internal_ID;
  logic       ID_Fail;
  logic       Locked;
  logic       Busy;

  modport slave (
    input  Game_Enter, User_digit, LogOut, rom_q,
    output rom_addr, Matched_ID, Internal_ID, ID_Fail, Locked, Busy
  );

  modport master (
    output Game_Enter, User_digit, LogOut, rom_q,
    input  rom_addr, Matched_ID, Internal_ID, ID_Fail, Locked, Busy
  );
endinterface

// File: rtl/user_id_controller.sv
// Collects a 4-digit user ID, scans the ID ROM nibble by nibble and reports match/fail.
// Match on entry k lands E*(k+1) cycles after the 4th digit; three straight fails lock the keypad.
module user_id_controller #(
  parameter int NUM_USERS   = 8,
  parameter int ROM_LAT     = 2,
  parameter int LOCK_CYCLES = 16
) (
  input logic                  clk,
  input logic                  rst,
  user_id_controller_if.slave  bus
);

  localparam int WAIT_W = $clog2(ROM_LAT + 1);
  localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ROM_LAT - 1);
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CYCLES);
  localparam logic [2:0]        K_LAST    = 3'(NUM_USERS - 1);
  localparam logic [15:0]       EMPTY_ID  = 16'hFFFF;

  typedef enum logic [2:0] {
    S_DIGITS,
    S_FETCH,
    S_WAIT,
    S_CATCH,
    S_CHECK,
    S_MATCHED,
    S_LOCKED
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       id_buf_q, id_buf_d;
  logic [15:0]       rom_buf_q, rom_buf_d;
  logic [1:0]        dcnt_q, dcnt_d;
  logic [1:0]        fails_q, fails_d;
  logic [2:0]        k_q, k_d;
  logic [1:0]        n_q, n_d;
  logic [WAIT_W-1:0] wcnt_q, wcnt_d;
  logic [LOCK_W-1:0] lcnt_q, lcnt_d;
  logic [4:0]        rom_addr_q, rom_addr_d;
  logic [4:0]        internal_id_q, internal_id_d;
  logic              matched_q, matched_d;
  logic              id_fail_q, id_fail_d;
  logic              locked_q, locked_d;
  logic              busy_q, busy_d;

  always_comb begin
    state_d       = state_q;
    id_buf_d      = id_buf_q;
    rom_buf_d     = rom_buf_q;
    dcnt_d        = dcnt_q;
    fails_d       = fails_q;
    k_d           = k_q;
    n_d           = n_q;
    wcnt_d        = wcnt_q;
    lcnt_d        = lcnt_q;
    rom_addr_d    = rom_addr_q;
    internal_id_d = internal_id_q;
    matched_d     = 1'b0;
    id_fail_d     = 1'b0;

    case (state_q)
      S_DIGITS: begin
        if (bus.Game_Enter) begin
          id_buf_d = {id_buf_q[11:0], bus.User_digit};
          dcnt_d   = dcnt_q + 2'd1;
          if (dcnt_q == 2'd3) begin
            dcnt_d  = 2'd0;
            k_d     = 3'd0;
            n_d     = 2'd0;
            state_d = S_FETCH;
          end
        end
      end

      S_FETCH: begin
        rom_addr_d = {k_q, n_q};
        wcnt_d     = '0;
        state_d    = S_WAIT;
      end

      S_WAIT: begin
        if (wcnt_q == WAIT_LAST) begin
          state_d = S_CATCH;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end

      S_CATCH: begin
        rom_buf_d = {rom_buf_q[11:0], bus.rom_q};
        if (n_q == 2'd3) begin
          state_d = S_CHECK;
        end else begin
          n_d     = n_q + 2'd1;
          state_d = S_FETCH;
        end
      end

      S_CHECK: begin
        // Empty slots hold FFFF, so an entered FFFF can never match one.
        if (rom_buf_q == id_buf_q && rom_buf_q != EMPTY_ID) begin
          matched_d     = 1'b1;
          internal_id_d = {k_q, 2'b00};
          fails_d       = 2'd0;
          state_d       = S_MATCHED;
        end else if (k_q < K_LAST) begin
          k_d     = k_q + 3'd1;
          n_d     = 2'd0;
          state_d = S_FETCH;
        end else begin
          id_fail_d = 1'b1;
          id_buf_d  = '0;
          if (fails_q == 2'd2) begin
            fails_d = 2'd0;
            lcnt_d  = '0;
            state_d = S_LOCKED;
          end else begin
            fails_d = fails_q + 2'd1;
            state_d = S_DIGITS;
          end
        end
      end

      S_MATCHED: begin
        if (bus.LogOut) begin
          internal_id_d = '0;
          id_buf_d      = '0;
          state_d       = S_DIGITS;
        end
      end

      S_LOCKED: begin
        // One extra cycle here lets ID_Fail show before Locked rises.
        if (lcnt_q == LOCK_LAST) begin
          state_d = S_DIGITS;
        end else begin
          lcnt_d = lcnt_q + 1'b1;
        end
      end

      default: state_d = S_DIGITS;
    endcase

    busy_d   = !(state_d == S_DIGITS || state_d == S_MATCHED);
    locked_d = (state_q == S_LOCKED) && (state_d == S_LOCKED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_DIGITS;
      id_buf_q      <= '0;
      rom_buf_q     <= '0;
      dcnt_q        <= '0;
      fails_q       <= '0;
      k_q           <= '0;
      n_q           <= '0;
      wcnt_q        <= '0;
      lcnt_q        <= '0;
      rom_addr_q    <= '0;
      internal_id_q <= '0;
      matched_q     <= 1'b0;
      id_fail_q     <= 1'b0;
      locked_q      <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      id_buf_q      <= id_buf_d;
      rom_buf_q     <= rom_buf_d;
      dcnt_q        <= dcnt_d;
      fails_q       <= fails_d;
      k_q           <= k_d;
      n_q           <= n_d;
      wcnt_q        <= wcnt_d;
      lcnt_q        <= lcnt_d;
      rom_addr_q    <= rom_addr_d;
      internal_id_q <= internal_id_d;
      matched_q     <= matched_d;
      id_fail_q     <= id_fail_d;
      locked_q      <= locked_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.rom_addr    = rom_addr_q;
  assign bus.Internal_ID = internal_id_q;
  assign bus.Matched_ID  = matched_q;
  assign bus.ID_Fail     = id_fail_q;
  assign bus.Locked      = locked_q;
  assign bus.Busy        = busy_q;

endmodule

// File: tb/tb_user_id_controller.sv
// Bench for user_id_controller: a latency-modelled ID ROM plus a scoreboard of expected
// Matched_ID / ID_Fail pulses (kind, cycle, Internal_ID) popped by a negedge monitor.
module tb_user_id_controller;

  localparam int NU = 8;
  localparam int RL = 2;
  localparam int LC = 16;
  localparam int P  = RL + 2;
  localparam int E  = 4 * P + 1;

  typedef struct {
    bit         is_match;
    int         cyc;
    logic [4:0] iid;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;
  exp_t sb[$];
  exp_t mon_e;

  logic [3:0] mem [32];
  logic [3:0] pipe [RL];

  user_id_controller_if bus();

  user_id_controller #(.NUM_USERS(NU), .ROM_LAT(RL), .LOCK_CYCLES(LC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ROM with RL registered stages between address and data
  always @(posedge clk) begin
    pipe[0] <= mem[bus.rom_addr];
    for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.rom_q = pipe[RL-1];

  always @(negedge clk) begin
    if (bus.Matched_ID === 1'b1 || bus.ID_Fail === 1'b1) begin
      n_assert++;
      if (bus.Matched_ID && bus.ID_Fail) begin
        n_fail++;
        $display("FAIL pulse_overlap: Matched_ID=1 and ID_Fail=1 at cycle %0d, required at most one", cyc);
      end else if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse: Matched_ID=%b ID_Fail=%b at cycle %0d, required no pulse",
                 bus.Matched_ID, bus.ID_Fail, cyc);
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.is_match !== bus.Matched_ID || mon_e.cyc != cyc ||
            (mon_e.is_match && bus.Internal_ID !== mon_e.iid)) begin
          n_fail++;
          $display("FAIL scoreboard: got match=%b cycle=%0d iid=%0d, required match=%b cycle=%0d iid=%0d",
                   bus.Matched_ID, cyc, bus.Internal_ID, mon_e.is_match, mon_e.cyc, mon_e.iid);
        end
      end
    end
  end

  task automatic set_entry(input int k, input logic [15:0] v);
    for (int i = 0; i < 4; i++) mem[4*k + i] = v[(3-i)*4 +: 4];
  endtask

  task automatic enter_id(input logic [15:0] id, input bit push, input bit is_match,
                          input int k, output int t);
    exp_t e;
    t = 0;
    for (int i = 3; i >= 0; i--) begin
      @(negedge clk);
      bus.Game_Enter = 1'b1;
      bus.User_digit = id[i*4 +: 4];
      if (i == 0) begin
        t          = cyc + 1;
        e.is_match = is_match;
        e.cyc      = is_match ? t + E * (k + 1) : t + E * NU;
        e.iid      = is_match ? 5'(4 * k) : 5'd0;
        if (push) sb.push_back(e);
      end
      @(negedge clk);
      bus.Game_Enter = 1'b0;
    end
  endtask

  task automatic wait_drain(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse_logout();
    @(negedge clk);
    bus.LogOut = 1'b1;
    @(negedge clk);
    bus.LogOut = 1'b0;
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_assert++;
    if ({bus.rom_addr, bus.Internal_ID, bus.Matched_ID, bus.ID_Fail, bus.Locked, bus.Busy} !== 14'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: addr=%0d iid=%0d m=%b f=%b l=%b b=%b, required all 0",
               bus.rom_addr, bus.Internal_ID, bus.Matched_ID, bus.ID_Fail, bus.Locked, bus.Busy);
    end
    rst = 1'b0;
  endtask

  task automatic test_match0();
    int t;
    bit ok;
    set_entry(0, 16'h1234);
    enter_id(16'h1234, 1'b1, 1'b1, 0, t);
    n_assert++;
    if (bus.Busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_rise: Busy=%b in cycle after 4th digit, required 1", bus.Busy);
    end
    for (int i = 0; i < 4; i++) begin
      while (cyc < t + 1 + P * i) @(negedge clk);
      n_assert++;
      if (bus.rom_addr !== 5'(i)) begin
        n_fail++;
        $display("FAIL rom_addr_seq[%0d]: rom_addr=%0d, required %0d", i, bus.rom_addr, i);
      end
    end
    wait_drain(E * NU + 20, ok);
    n_assert++;
    if (!ok || bus.Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL match0_done: drained=%b Busy=%b, required drained=1 Busy=0", ok, bus.Busy);
    end
    pulse_logout();
  endtask

  task automatic test_match5();
    int t;
    bit ok;
    set_entry(5, 16'hA0B7);
    enter_id(16'hA0B7, 1'b1, 1'b1, 5, t);
    wait_drain(E * NU + 20, ok);
    repeat (3) @(negedge clk);
    n_assert++;
    if (!ok || bus.Internal_ID !== 5'd20) begin
      n_fail++;
      $display("FAIL match5_hold: drained=%b Internal_ID=%0d, required drained=1 Internal_ID=20",
               ok, bus.Internal_ID);
    end
    // LogOut and a digit press in the same cycle: the press must be dropped
    @(negedge clk);
    bus.LogOut     = 1'b1;
    bus.Game_Enter = 1'b1;
    bus.User_digit = 4'h9;
    @(negedge clk);
    bus.LogOut     = 1'b0;
    bus.Game_Enter = 1'b0;
    #1;
    n_assert++;
    if (bus.Internal_ID !== 5'd0 || bus.Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL logout_clear: Internal_ID=%0d Busy=%b, required 0 and 0", bus.Internal_ID, bus.Busy);
    end
    enter_id(16'h1234, 1'b1, 1'b1, 0, t);
    wait_drain(E * NU + 20, ok);
    n_assert++;
    if (!ok) begin
      n_fail++;
      $display("FAIL after_logout_match: no pulse seen, required match on entry 0");
    end
    pulse_logout();
  endtask

  task automatic test_lockout();
    int t;
    bit ok;
    int hi;
    int first;
    for (int r = 0; r < 3; r++) begin
      enter_id(16'h9999, 1'b1, 1'b0, 0, t);
      wait_drain(E * NU + 20, ok);
      n_assert++;
      if (!ok || bus.Locked !== 1'b0) begin
        n_fail++;
        $display("FAIL fail_%0d: drained=%b Locked=%b, required drained=1 Locked=0", r, ok, bus.Locked);
      end
    end
    hi = 0;
    first = -1;
    for (int j = 1; j <= LC + 4; j++) begin
      @(negedge clk);
      #1;
      if (bus.Locked === 1'b1) begin
        hi++;
        if (first < 0) first = j;
      end
      if (j == 1) begin
        n_assert++;
        if (bus.Busy !== 1'b1) begin
          n_fail++;
          $display("FAIL busy_locked: Busy=%b during lockout, required 1", bus.Busy);
        end
      end
      bus.Game_Enter = (j < LC) && (j % 2 == 1);
      bus.User_digit = 4'((j / 2) % 4 + 1);
    end
    bus.Game_Enter = 1'b0;
    n_assert++;
    if (hi != LC || first != 1) begin
      n_fail++;
      $display("FAIL lock_window: Locked high %0d cycles starting at +%0d, required %0d starting at +1",
               hi, first, LC);
    end
    enter_id(16'h1234, 1'b1, 1'b1, 0, t);
    wait_drain(E * NU + 20, ok);
    n_assert++;
    if (!ok) begin
      n_fail++;
      $display("FAIL post_lock_match: no pulse seen, required match on entry 0");
    end
    pulse_logout();
  endtask

  task automatic test_empty_slot();
    int t;
    bit ok;
    set_entry(2, 16'hFFFF);
    enter_id(16'hFFFF, 1'b1, 1'b0, 0, t);
    wait_drain(E * NU + 20, ok);
    n_assert++;
    if (!ok || bus.Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_slot: drained=%b Busy=%b, required drained=1 Busy=0", ok, bus.Busy);
    end
  endtask

  task automatic test_fail_clear();
    int t;
    bit ok;
    int hi;
    pulse_rst();
    for (int r = 0; r < 5; r++) begin
      enter_id(r == 2 ? 16'h1234 : 16'h9999, 1'b1, r == 2, 0, t);
      wait_drain(E * NU + 20, ok);
      n_assert++;
      if (!ok) begin
        n_fail++;
        $display("FAIL fail_clear_step%0d: no pulse seen, required one", r);
      end
      if (r == 2) pulse_logout();
    end
    hi = 0;
    repeat (LC + 4) begin
      @(negedge clk);
      if (bus.Locked === 1'b1 || bus.Busy === 1'b1) hi++;
    end
    n_assert++;
    if (hi != 0) begin
      n_fail++;
      $display("FAIL no_lockout: Locked/Busy high %0d cycles, required 0", hi);
    end
  endtask

  task automatic test_reset_midscan();
    int t;
    bit ok;
    pulse_rst();
    enter_id(16'h9999, 1'b1, 1'b0, 0, t);
    repeat (5) @(negedge clk);
    bus.Game_Enter = 1'b1;
    bus.User_digit = 4'h7;
    @(negedge clk);
    bus.Game_Enter = 1'b0;
    wait_drain(E * NU + 20, ok);
    n_assert++;
    if (!ok) begin
      n_fail++;
      $display("FAIL midscan_first: no pulse seen, required ID_Fail");
    end
    enter_id(16'h9999, 1'b0, 1'b0, 0, t);
    while (cyc < t + 39) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_assert++;
    if ({bus.rom_addr, bus.Internal_ID, bus.Matched_ID, bus.ID_Fail, bus.Locked, bus.Busy} !== 14'd0) begin
      n_fail++;
      $display("FAIL midscan_reset: addr=%0d iid=%0d m=%b f=%b l=%b b=%b, required all 0",
               bus.rom_addr, bus.Internal_ID, bus.Matched_ID, bus.ID_Fail, bus.Locked, bus.Busy);
    end
    enter_id(16'h1234, 1'b1, 1'b1, 0, t);
    wait_drain(E * NU + 20, ok);
    n_assert++;
    if (!ok || bus.Internal_ID !== 5'd0) begin
      n_fail++;
      $display("FAIL fresh_id_match: drained=%b Internal_ID=%0d, required drained=1 Internal_ID=0",
               ok, bus.Internal_ID);
    end
    pulse_logout();
  endtask

  initial begin
    rst            = 1'b1;
    bus.Game_Enter = 1'b0;
    bus.User_digit = 4'h0;
    bus.LogOut     = 1'b0;
    for (int k = 0; k < 8; k++) set_entry(k, 16'h6000 | 16'(k));

    test_reset();
    test_match0();
    test_match5();
    test_lockout();
    test_empty_slot();
    test_fail_clear();
    test_reset_midscan();

    repeat (5) @(negedge clk);
    n_assert++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_left: %0d entries pending, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
